// File: rtl/surv_mem_sched_pkg.sv
// surv_mem_sched_pkg: survivor memory geometry and scheduler state encoding
package surv_mem_sched_pkg;
  localparam int NUM_COL = 8;
  localparam int COL_W = 32;
  localparam int DEPTH = 8;
  localparam int SEL_W = 3;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {FILL, LOAD, DRAIN} state_t;
endpackage

// File: rtl/surv_col_mux.sv
// surv_col_mux: combinational NUM_COL:1 word select over the concatenated columns
module surv_col_mux
  import surv_mem_sched_pkg::*;
(
  input  logic [NUM_COL*COL_W-1:0] col_data,
  input  logic [SEL_W-1:0]         sel,
  output logic [COL_W-1:0]         word
);
  assign word = col_data[sel*COL_W +: COL_W];
endmodule

// File: rtl/surv_mem_sched.sv
// surv_mem_sched: gates survivor column shifting and drains full/terminated blocks word by word
module surv_mem_sched
  import surv_mem_sched_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dec_valid,
  input  logic                     dec_term,
  output logic                     dec_ready,
  output logic                     shift_en,
  input  logic [NUM_COL*COL_W-1:0] col_data,
  output logic [SEL_W-1:0]         col_sel,
  output logic [COL_W-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy
);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_COL - 1);
  state_t state;
  logic [CNT_W-1:0] fill_cnt;
  logic term_pend;
  logic [SEL_W-1:0] nxt_sel;
  logic [COL_W-1:0] word;
  assign dec_ready = state == FILL;
  assign shift_en = dec_valid & dec_ready;
  // mux looks one column ahead on a drain handshake so the next word loads without a bubble
  assign nxt_sel = (state == DRAIN && out_ready && col_sel != LAST_SEL) ? col_sel + 1'b1 : col_sel;
  assign out_last = out_valid & term_pend & (col_sel == LAST_SEL);
  assign busy = !(state == FILL && fill_cnt == '0);
  surv_col_mux u_mux (.col_data(col_data), .sel(nxt_sel), .word(word));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FILL;
      fill_cnt <= '0;
      term_pend <= 1'b0;
      col_sel <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        FILL: if (dec_valid) begin
          fill_cnt <= fill_cnt + 1'b1;
          if (dec_term) term_pend <= 1'b1;
          if (dec_term || fill_cnt == CNT_W'(DEPTH - 1)) state <= LOAD;
        end
        LOAD: begin
          out_data <= word;
          out_valid <= 1'b1;
          state <= DRAIN;
        end
        DRAIN: if (out_ready) begin
          if (col_sel == LAST_SEL) begin
            out_valid <= 1'b0;
            col_sel <= '0;
            fill_cnt <= '0;
            term_pend <= 1'b0;
            state <= FILL;
          end else begin
            col_sel <= nxt_sel;
            out_data <= word;
          end
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_surv_mem_sched.sv
// tb_surv_mem_sched: table-driven vectors plus directed multi-cycle sequences for surv_mem_sched
module tb_surv_mem_sched;
  logic clk = 0, rst = 0, dv = 0, dt = 0, ordy = 0;
  logic [255:0] col_data;
  logic dec_ready, shift_en, out_valid, out_last, busy;
  logic [2:0] col_sel;
  logic [31:0] out_data;
  int n_cmp = 0, n_err = 0;
  typedef struct {
    logic dv, dt, ordy, dr, sh, ov;
    logic [2:0] sel;
    logic last, busy;
  } row_t;
  row_t rows[$];
  surv_mem_sched dut (
    .clk(clk), .rst(rst), .dec_valid(dv), .dec_term(dt), .dec_ready(dec_ready),
    .shift_en(shift_en), .col_data(col_data), .col_sel(col_sel), .out_data(out_data),
    .out_valid(out_valid), .out_ready(ordy), .out_last(out_last), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] pat(int k);
    return 32'hA5A5_0000 + k;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic add(logic a, logic b, logic c, logic d, logic e, logic f, logic [2:0] g, logic h, logic i);
    rows.push_back('{a, b, c, d, e, f, g, h, i});
  endtask
  task automatic go();
    @(posedge clk);
    #1;
  endtask
  task automatic fill(int n);
    dv = 1;
    repeat (n) go();
    dv = 0;
  endtask
  initial begin
    int exp_sel, cyc;
    for (int k = 0; k < 8; k++) col_data[k*32 +: 32] = pat(k);
    for (int i = 0; i < 8; i++) add(1, 0, 1, 1, 1, 0, 0, 0, i != 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 8; k++) add(0, 0, 1, 0, 0, 1, 3'(k), 0, 1);
    add(0, 1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(1, i == 2, 0, 1, 1, 0, 0, 0, i != 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 8; k++) add(0, 0, 1, 0, 0, 1, 3'(k), k == 7, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0);
    #12;
    chk("rst_dec_ready", 32'(dec_ready), 1);
    chk("rst_shift_en", 32'(shift_en), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_col_sel", 32'(col_sel), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_last", 32'(out_last), 0);
    rst = 1;
    go();
    foreach (rows[r]) begin
      dv = rows[r].dv; dt = rows[r].dt; ordy = rows[r].ordy;
      @(negedge clk);
      chk($sformatf("row%0d_dec_ready", r), 32'(dec_ready), 32'(rows[r].dr));
      chk($sformatf("row%0d_shift_en", r), 32'(shift_en), 32'(rows[r].sh));
      chk($sformatf("row%0d_out_valid", r), 32'(out_valid), 32'(rows[r].ov));
      chk($sformatf("row%0d_col_sel", r), 32'(col_sel), 32'(rows[r].sel));
      chk($sformatf("row%0d_out_last", r), 32'(out_last), 32'(rows[r].last));
      chk($sformatf("row%0d_busy", r), 32'(busy), 32'(rows[r].busy));
      if (rows[r].ov) chk($sformatf("row%0d_out_data", r), out_data, pat(int'(rows[r].sel)));
      go();
    end
    dv = 0; dt = 0; ordy = 0;
    fill(8);
    go();
    exp_sel = 0;
    cyc = 0;
    while (exp_sel < 8 && cyc < 40) begin
      ordy = (cyc % 3) == 0;
      @(negedge clk);
      chk("t2_out_valid", 32'(out_valid), 1);
      chk("t2_col_sel", 32'(col_sel), 32'(exp_sel));
      chk("t2_out_data", out_data, pat(exp_sel));
      chk("t2_dec_ready", 32'(dec_ready), 0);
      if (ordy) exp_sel++;
      go();
      cyc++;
    end
    ordy = 0;
    chk("t2_words_delivered", 32'(exp_sel), 8);
    @(negedge clk);
    chk("t2_dec_ready_back", 32'(dec_ready), 1);
    go();
    fill(8);
    dv = 1;
    ordy = 1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk("t4_no_shift_in_drain", 32'(shift_en), 0);
      go();
    end
    @(negedge clk);
    chk("t4_first_fill_shift", 32'(shift_en), 1);
    chk("t4_first_fill_ready", 32'(dec_ready), 1);
    go();
    dv = 1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("t4_still_filling", 32'(dec_ready), 1);
      go();
    end
    dv = 0;
    @(negedge clk);
    chk("t4_load_after_8", 32'(dec_ready), 0);
    go();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t4_col_sel", 32'(col_sel), 32'(k));
      chk("t4_no_last", 32'(out_last), 0);
      go();
    end
    ordy = 0;
    fill(8);
    go();
    ordy = 1;
    repeat (4) go();
    ordy = 0;
    chk("t5_pre_sel", 32'(col_sel), 4);
    #2 rst = 0;
    #1;
    chk("t5_async_out_valid", 32'(out_valid), 0);
    chk("t5_async_col_sel", 32'(col_sel), 0);
    chk("t5_async_dec_ready", 32'(dec_ready), 1);
    chk("t5_async_out_data", out_data, 0);
    #1 rst = 1;
    go();
    fill(8);
    go();
    @(negedge clk);
    chk("t5_refill_valid", 32'(out_valid), 1);
    chk("t5_refill_sel", 32'(col_sel), 0);
    chk("t5_refill_data", out_data, pat(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
